// File: rtl/cam_wr_decoder.sv
// Registered write-enable decoder for the CAM entry array: single, wrapping burst and
// broadcast writes, accepted over a valid/ready handshake.
module cam_wr_decoder #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned ENTRIES = 2**ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [1:0]         req_mode_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [ADDR_W-1:0]  req_len_i,
  input  logic               abort_i,
  output logic [ENTRIES-1:0] en_o,
  output logic               en_valid_o,
  output logic [ADDR_W-1:0]  en_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W:0]   NumEntries = (ADDR_W + 1)'(ENTRIES);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ENTRIES-1:0] en_q, en_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               bcast_d;

  logic               accept;
  logic               bad_req;
  logic [ADDR_W-1:0]  nxt_idx;
  logic [ADDR_W-1:0]  clamp_len;

  assign nxt_idx   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
  // Clamping to ENTRIES-1 keeps a burst from lapping the array and rewriting an entry.
  assign clamp_len = (req_len_i > LastIdx) ? LastIdx : req_len_i;
  assign bad_req   = (req_mode_i == 2'b11) || ({1'b0, req_addr_i} >= NumEntries);

  // Ready rises on the last burst beat so the next request follows with no gap;
  // an abort on that cycle wins over acceptance.
  always_comb begin
    req_ready_o = (state_q == StIdle) || ((rem_q == '0) && !abort_i);
  end

  assign accept = req_valid_i && req_ready_o;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (state_q == StBurst) begin
      if (abort_i || (rem_q == '0)) begin
        state_d = StIdle;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
    if (accept) begin
      state_d = StIdle;
      rem_d   = '0;
      if (!bad_req && (req_mode_i == 2'b01) && (req_len_i != '0)) begin
        state_d = StBurst;
        rem_d   = clamp_len;
      end
    end
  end

  // Beat decode, registered below
  always_comb begin
    valid_d = 1'b0;
    idx_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bcast_d = 1'b0;
    if ((state_q == StBurst) && !abort_i && (rem_q != '0)) begin
      valid_d = 1'b1;
      idx_d   = nxt_idx;
      done_d  = (rem_q == ADDR_W'(1));
    end
    if (accept) begin
      if (bad_req) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        case (req_mode_i)
          2'b10: begin
            bcast_d = 1'b1;
            idx_d   = '0;
            done_d  = 1'b1;
          end
          2'b01: begin
            idx_d  = req_addr_i;
            done_d = (req_len_i == '0);
          end
          default: begin
            idx_d  = req_addr_i;
            done_d = 1'b1;
          end
        endcase
      end
    end
    if (bcast_d) begin
      en_d = '1;
    end else if (valid_d) begin
      en_d = ENTRIES'(1) << idx_d;
    end else begin
      en_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rem_q   <= '0;
      idx_q   <= '0;
      en_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign en_o       = en_q;
  assign en_valid_o = valid_q;
  assign en_idx_o   = idx_q;
  assign busy_o     = (state_q == StBurst);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_cam_wr_decoder.sv
// Randomised bench for cam_wr_decoder: two instances (32 and 20 entries) share stimulus and
// are checked every cycle against a pending-beat model, plus hand-computed directed checks.
module tb_cam_wr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_mode;
  logic [4:0]  req_addr;
  logic [4:0]  req_len;
  logic        abort;

  logic        ready0, ready1;
  logic [31:0] en0;
  logic [19:0] en1;
  logic        valid0, valid1, busy0, busy1, done0, done1, err0, err1;
  logic [4:0]  idx0, idx1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cam_wr_decoder #(.ADDR_W(5), .ENTRIES(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready0),
    .req_mode_i(req_mode), .req_addr_i(req_addr), .req_len_i(req_len), .abort_i(abort),
    .en_o(en0), .en_valid_o(valid0), .en_idx_o(idx0), .busy_o(busy0), .done_o(done0),
    .err_o(err0)
  );

  cam_wr_decoder #(.ADDR_W(5), .ENTRIES(20)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_mode_i(req_mode), .req_addr_i(req_addr), .req_len_i(req_len), .abort_i(abort),
    .en_o(en1), .en_valid_o(valid1), .en_idx_o(idx1), .busy_o(busy1), .done_o(done1),
    .err_o(err1)
  );

  // Model: beats still owed to the array, plus the beat currently on the outputs.
  int ent [2] = '{32, 20};
  int pend [2];
  int nidx [2];
  int cidx [2];
  bit nbc [2];
  bit multi [2];
  bit cv [2];
  bit cbc [2];
  bit cdone [2];
  bit cbusy [2];
  bit cerr [2];
  bit rdy [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; nidx[i] = 0; cidx[i] = 0; nbc[i] = 0; multi[i] = 0;
      cv[i] = 0; cbc[i] = 0; cdone[i] = 0; cbusy[i] = 0; cerr[i] = 0; rdy[i] = 1;
    end
  endtask

  task automatic model_edge(input int i);
    int n;
    bit nerr;
    nerr = 0;
    if (cbusy[i] && abort) pend[i] = 0;
    if (req_valid && rdy[i]) begin
      if (req_mode == 2'b11 || int'(req_addr) >= ent[i]) begin
        nerr = 1;
      end else if (req_mode == 2'b10) begin
        pend[i] = 1; nidx[i] = 0; nbc[i] = 1; multi[i] = 0;
      end else begin
        n = (req_mode == 2'b01) ? ((int'(req_len) < ent[i] - 1) ? int'(req_len) : ent[i] - 1) + 1
                                : 1;
        pend[i] = n; nidx[i] = int'(req_addr); nbc[i] = 0; multi[i] = (n > 1);
      end
    end
    if (pend[i] > 0) begin
      cv[i] = 1; cidx[i] = nidx[i]; cbc[i] = nbc[i]; cbusy[i] = multi[i];
      pend[i]--;
      cdone[i] = (pend[i] == 0);
      nidx[i] = (nidx[i] + 1) % ent[i];
    end else begin
      cv[i] = 0; cidx[i] = 0; cbc[i] = 0; cbusy[i] = 0; cdone[i] = 0;
    end
    cerr[i] = nerr;
  endtask

  function automatic logic [31:0] exp_en(input int i);
    if (!cv[i]) return 32'd0;
    if (cbc[i]) return (ent[i] == 32) ? 32'hffff_ffff : (32'd1 << ent[i]) - 32'd1;
    return 32'd1 << cidx[i];
  endfunction

  task automatic step(input bit v, input bit [1:0] m, input bit [4:0] a, input bit [4:0] l,
                      input bit ab, input bit r);
    req_valid = v; req_mode = m; req_addr = a; req_len = l; abort = ab; rst = r;
    #1;
    for (int i = 0; i < 2; i++) rdy[i] = !cbusy[i] || (pend[i] == 0 && !ab);
    if (!r) begin
      chk("ready0", {31'd0, ready0}, {31'd0, rdy[0]});
      chk("ready1", {31'd0, ready1}, {31'd0, rdy[1]});
    end
    @(posedge clk);
    if (r) model_reset();
    else for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    chk("en0", en0, exp_en(0));
    chk("en_valid0", {31'd0, valid0}, {31'd0, cv[0]});
    chk("en_idx0", {27'd0, idx0}, cidx[0]);
    chk("busy0", {31'd0, busy0}, {31'd0, cbusy[0]});
    chk("done0", {31'd0, done0}, {31'd0, cdone[0]});
    chk("err0", {31'd0, err0}, {31'd0, cerr[0]});
    chk("en1", {12'd0, en1}, exp_en(1));
    chk("en_valid1", {31'd0, valid1}, {31'd0, cv[1]});
    chk("en_idx1", {27'd0, idx1}, cidx[1]);
    chk("busy1", {31'd0, busy1}, {31'd0, cbusy[1]});
    chk("done1", {31'd0, done1}, {31'd0, cdone[1]});
    chk("err1", {31'd0, err1}, {31'd0, cerr[1]});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 2'b00, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    int beats0, beats1;
    bit [1:0] m;
    bit [4:0] l;
    model_reset();
    rst = 1; req_valid = 0; req_mode = 0; req_addr = 0; req_len = 0; abort = 0;
    @(negedge clk);
    step(0, 2'b00, 5'd0, 5'd0, 0, 1);
    step(0, 2'b00, 5'd0, 5'd0, 0, 1);
    idle();
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_en", en0, 32'd0);

    // single addr 5
    step(1, 2'b00, 5'd5, 5'd0, 0, 0);
    chk("t1_en", en0, 32'h20);
    chk("t1_idx", {27'd0, idx0}, 32'd5);
    chk("t1_done", {31'd0, done0}, 32'd1);
    idle();
    chk("t1_off", en0, 32'd0);

    // burst wrap 30,31,0,1
    step(1, 2'b01, 5'd30, 5'd3, 0, 0);
    chk("t2_b0", {27'd0, idx0}, 32'd30);
    chk("t2_err20", {31'd0, err1}, 32'd1);
    idle();
    chk("t2_b1", {27'd0, idx0}, 32'd31);
    chk("t2_busy", {31'd0, busy0}, 32'd1);
    idle();
    chk("t2_b2", {27'd0, idx0}, 32'd0);
    chk("t2_b2_en", en0, 32'd1);
    idle();
    chk("t2_b3", {27'd0, idx0}, 32'd1);
    chk("t2_done", {31'd0, done0}, 32'd1);
    idle();
    chk("t2_end", {31'd0, valid0}, 32'd0);

    // back-to-back: burst 0..1 then held single 9
    step(1, 2'b01, 5'd0, 5'd1, 0, 0);
    step(1, 2'b00, 5'd9, 5'd0, 0, 0);
    chk("t3_b1", {27'd0, idx0}, 32'd1);
    chk("t3_done1", {31'd0, done0}, 32'd1);
    step(1, 2'b00, 5'd9, 5'd0, 0, 0);
    chk("t3_b2", {27'd0, idx0}, 32'd9);
    chk("t3_done2", {31'd0, done0}, 32'd1);
    idle();

    // rejections
    step(1, 2'b00, 5'd25, 5'd0, 0, 0);
    chk("t4_err_addr", {31'd0, err1}, 32'd1);
    chk("t4_noval", {31'd0, valid1}, 32'd0);
    step(1, 2'b11, 5'd0, 5'd0, 0, 0);
    chk("t4_err_mode", {31'd0, err1}, 32'd1);
    chk("t4_ready", {31'd0, ready1}, 32'd1);
    idle();
    chk("t4_pulse", {31'd0, err1}, 32'd0);

    // abort at idx 6
    step(1, 2'b01, 5'd4, 5'd7, 0, 0);
    idle();
    idle();
    chk("t5_idx6", {27'd0, idx0}, 32'd6);
    step(0, 2'b00, 5'd0, 5'd0, 1, 0);
    chk("t5_nobeat", {31'd0, valid0}, 32'd0);
    chk("t5_nodone", {31'd0, done0}, 32'd0);
    chk("t5_ready", {31'd0, ready0}, 32'd1);
    idle();
    // reset at idx 6
    step(1, 2'b01, 5'd4, 5'd7, 0, 0);
    idle();
    idle();
    step(0, 2'b00, 5'd0, 5'd0, 0, 1);
    chk("t5_rst_en", en0, 32'd0);
    chk("t5_rst_busy", {31'd0, busy0}, 32'd0);
    idle();
    chk("t5_rst_after", {31'd0, valid0}, 32'd0);

    // broadcast and clamp
    step(1, 2'b10, 5'd3, 5'd0, 0, 0);
    chk("t6_bc0", en0, 32'hffff_ffff);
    chk("t6_bc1", {12'd0, en1}, 32'h000f_ffff);
    chk("t6_idx", {27'd0, idx0}, 32'd0);
    idle();
    chk("t6_bc_off", en0, 32'd0);
    step(1, 2'b01, 5'd0, 5'd31, 0, 0);
    beats0 = int'(valid0);
    beats1 = int'(valid1);
    for (int k = 0; k < 40; k++) begin
      idle();
      beats0 += int'(valid0);
      beats1 += int'(valid1);
    end
    chk("t6_clamp20", beats1, 32'd20);
    chk("t6_clamp32", beats0, 32'd32);

    // randomised traffic
    for (int k = 0; k < 3000; k++) begin
      m = 2'($urandom_range(0, 7) < 5 ? $urandom_range(0, 2) : $urandom_range(0, 3));
      l = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
      step($urandom_range(0, 1) == 1, m, 5'($urandom), l, $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
